// File: rtl/gru_param_loader.sv
// Streaming parameter loader for the gru datapath. Words arrive one per
// valid/ready beat in a fixed order (x, h, six weight matrices, six bias
// vectors) and are held in a register bank that drives the gru operands as
// flattened buses. An h write-back port lets y be recirculated as h between
// timesteps without a full reload.
module gru_param_loader #(
    parameter int INT_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 8,
    parameter int WIDTH       = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int INPUT_SIZE  = 4,
    parameter int HIDDEN_SIZE = 2,
    parameter int TOTAL_WORDS = INPUT_SIZE + HIDDEN_SIZE
                              + 3 * INPUT_SIZE * HIDDEN_SIZE
                              + 3 * HIDDEN_SIZE * HIDDEN_SIZE
                              + 6 * HIDDEN_SIZE,
    localparam int CW         = $clog2(TOTAL_WORDS + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          start_i,
    input  logic                                          s_valid_i,
    input  logic [WIDTH-1:0]                              s_data_i,
    input  logic                                          s_last_i,
    output logic                                          s_ready_o,
    input  logic                                          h_wr_i,
    input  logic [HIDDEN_SIZE*WIDTH-1:0]                  h_in_i,
    output logic [INPUT_SIZE*WIDTH-1:0]                   x_flat_o,
    output logic [HIDDEN_SIZE*WIDTH-1:0]                  h_flat_o,
    output logic [3*INPUT_SIZE*HIDDEN_SIZE*WIDTH-1:0]     w_i_flat_o,
    output logic [3*HIDDEN_SIZE*HIDDEN_SIZE*WIDTH-1:0]    w_h_flat_o,
    output logic [6*HIDDEN_SIZE*WIDTH-1:0]                b_flat_o,
    output logic                                          params_valid_o,
    output logic                                          busy_o,
    output logic                                          err_o,
    output logic [CW-1:0]                                 word_count_o
);

    // Slot offsets of each operand group inside the bank
    localparam int X_OFF  = 0;
    localparam int H_OFF  = X_OFF + INPUT_SIZE;
    localparam int WI_OFF = H_OFF + HIDDEN_SIZE;
    localparam int WH_OFF = WI_OFF + 3 * INPUT_SIZE * HIDDEN_SIZE;
    localparam int B_OFF  = WH_OFF + 3 * HIDDEN_SIZE * HIDDEN_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic          pv_q;

    logic [WIDTH-1:0] bank_w [TOTAL_WORDS];

    // A beat is accepted in LOAD whenever valid is high; it is well framed
    // only if s_last marks exactly the final slot.
    logic is_last_slot;
    logic beat_acc;
    logic beat_ok;
    logic h_we;

    assign is_last_slot = (count_q == CW'(TOTAL_WORDS - 1));
    assign beat_acc     = (state_q == ST_LOAD) && s_valid_i;
    assign beat_ok      = beat_acc && (s_last_i == is_last_slot);
    assign h_we         = h_wr_i && (state_q != ST_LOAD);

    // Load sequencing: IDLE/DONE wait for start, LOAD counts framed beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        pv_q    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat_acc) begin
                        if (!beat_ok) begin
                            // Framing error: drop the beat and abandon the load
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            count_q <= count_q + 1'b1;
                            if (is_last_slot) begin
                                state_q <= ST_DONE;
                                pv_q    <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // One register per bank slot; h slots also take the write-back port
    for (genvar gi = 0; gi < TOTAL_WORDS; gi++) begin : g_slot
        localparam bit IS_H = (gi >= H_OFF) && (gi < H_OFF + HIDDEN_SIZE);
        localparam int HK   = IS_H ? (gi - H_OFF) : 0;

        logic [WIDTH-1:0] word_q;
        logic [WIDTH-1:0] word_d;
        logic             word_we;

        // Stream write and h write-back never coincide: one needs LOAD, the other not
        always_comb begin
            word_we = 1'b0;
            word_d  = word_q;
            if (beat_ok && (count_q == CW'(gi))) begin
                word_we = 1'b1;
                word_d  = s_data_i;
            end else if (IS_H && h_we) begin
                word_we = 1'b1;
                word_d  = h_in_i[HK*WIDTH +: WIDTH];
            end
        end

        // Slot storage, cleared by reset so no partial load survives
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_q <= '0;
            end else if (word_we) begin
                word_q <= word_d;
            end
        end

        assign bank_w[gi] = word_q;
    end

    // Map bank slots onto the operand buses; element e of a group at bits e*WIDTH
    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_x
        assign x_flat_o[gi*WIDTH +: WIDTH] = bank_w[X_OFF + gi];
    end
    for (genvar gi = 0; gi < HIDDEN_SIZE; gi++) begin : g_h
        assign h_flat_o[gi*WIDTH +: WIDTH] = bank_w[H_OFF + gi];
    end
    for (genvar gi = 0; gi < 3 * INPUT_SIZE * HIDDEN_SIZE; gi++) begin : g_wi
        assign w_i_flat_o[gi*WIDTH +: WIDTH] = bank_w[WI_OFF + gi];
    end
    for (genvar gi = 0; gi < 3 * HIDDEN_SIZE * HIDDEN_SIZE; gi++) begin : g_wh
        assign w_h_flat_o[gi*WIDTH +: WIDTH] = bank_w[WH_OFF + gi];
    end
    for (genvar gi = 0; gi < 6 * HIDDEN_SIZE; gi++) begin : g_b
        assign b_flat_o[gi*WIDTH +: WIDTH] = bank_w[B_OFF + gi];
    end

    assign s_ready_o      = (state_q == ST_LOAD);
    assign busy_o         = (state_q == ST_LOAD);
    assign params_valid_o = pv_q;
    assign err_o          = err_q;
    assign word_count_o   = count_q;

endmodule

// File: tb/tb_gru_param_loader.sv
// Self-checking bench for gru_param_loader: full loads with and without
// valid gaps, framing errors, h write-back and asynchronous reset mid-load.
module tb_gru_param_loader;

    localparam int W     = 17;
    localparam int I     = 4;
    localparam int H     = 2;
    localparam int TOTAL = 54;
    localparam int CW    = 6;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic                    s_valid;
    logic [W-1:0]            s_data;
    logic                    s_last;
    logic                    s_ready;
    logic                    h_wr;
    logic [H*W-1:0]          h_in;
    logic [I*W-1:0]          x_flat;
    logic [H*W-1:0]          h_flat;
    logic [3*I*H*W-1:0]      w_i_flat;
    logic [3*H*H*W-1:0]      w_h_flat;
    logic [6*H*W-1:0]        b_flat;
    logic                    params_valid;
    logic                    busy;
    logic                    err;
    logic [CW-1:0]           word_count;

    gru_param_loader dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .s_valid_i      (s_valid),
        .s_data_i       (s_data),
        .s_last_i       (s_last),
        .s_ready_o      (s_ready),
        .h_wr_i         (h_wr),
        .h_in_i         (h_in),
        .x_flat_o       (x_flat),
        .h_flat_o       (h_flat),
        .w_i_flat_o     (w_i_flat),
        .w_h_flat_o     (w_h_flat),
        .b_flat_o       (b_flat),
        .params_valid_o (params_valid),
        .busy_o         (busy),
        .err_o          (err),
        .word_count_o   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ready_cnt = 0;

    // Count cycles in which the loader offers s_ready
    always @(negedge clk) if (s_ready === 1'b1) ready_cnt++;

    typedef struct {
        int           slot;
        logic [W-1:0] val;
    } sb_t;
    sb_t          sb_q[$];
    logic [W-1:0] mdl [TOTAL];

    typedef struct {
        string        name;
        int           slot;
        logic [W-1:0] exp;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] get_slot(input int s);
        if (s < I)               return x_flat[s*W +: W];
        else if (s < I+H)        return h_flat[(s-I)*W +: W];
        else if (s < I+H+3*I*H)  return w_i_flat[(s-I-H)*W +: W];
        else if (s < 42)         return w_h_flat[(s-I-H-3*I*H)*W +: W];
        else                     return b_flat[(s-42)*W +: W];
    endfunction

    // Pop every expected write recorded during stimulus and compare the bank
    task automatic drain(input string tag);
        int n = 0;
        int bad = 0;
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            checks++;
            n++;
            if (get_slot(e.slot) !== e.val) begin
                failures++;
                bad++;
                $display("FAIL %s slot %0d: got %0d expected %0d", tag, e.slot, get_slot(e.slot), e.val);
            end
        end
        $display("%s: %0d scoreboard entries compared, %0d wrong", tag, n, bad);
    endtask

    // Compare the whole bank against the model
    task automatic check_bank(input string tag);
        for (int s = 0; s < TOTAL; s++) begin
            checks++;
            if (get_slot(s) !== mdl[s]) begin
                failures++;
                $display("FAIL %s slot %0d: got %0d expected %0d", tag, s, get_slot(s), mdl[s]);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ready_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive nb beats with data base+n; s_last on beat last_at; optional idle gaps.
    // Stops after a beat that must raise a framing error.
    task automatic stream(input int nb, input int last_at, input bit gap, input int base);
        for (int n = 0; n < nb; n++) begin
            bit bad;
            if (gap && n > 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(negedge clk);
            end
            bad     = ((n == last_at) != (n == TOTAL-1));
            s_valid = 1'b1;
            s_data  = W'(base + n);
            s_last  = (n == last_at);
            if (!bad) begin
                sb_t e;
                e.slot = n;
                e.val  = W'(base + n);
                sb_q.push_back(e);
                mdl[n] = W'(base + n);
            end
            @(negedge clk);
            if (bad) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"x0",       0, 17'd0};
        tbl[1] = '{"h1",       5, 17'd5};
        tbl[2] = '{"w_ir31",  13, 17'd13};
        tbl[3] = '{"w_iz00",  22, 17'd22};
        tbl[4] = '{"w_hn10",  35, 17'd35};
        tbl[5] = '{"b_hz1",   53, 17'd53};

        for (int s = 0; s < TOTAL; s++) mdl[s] = '0;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        h_wr = 1'b0; h_in = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_pv", 32'(params_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_count", 32'(word_count), 0);
        check_bank("rst_bank");
        $display("reset state checked");
        rst_n = 1'b1;

        // 1: contiguous full load, data = slot index
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        stream(TOTAL, TOTAL-1, 1'b0, 0);
        chk("t1_ready_cycles", 32'(ready_cnt), 54);
        chk("t1_pv", 32'(params_valid), 1);
        chk("t1_count", 32'(word_count), 54);
        chk("t1_ready_done", 32'(s_ready), 0);
        chk("t1_err", 32'(err), 0);
        for (int k = 0; k < 6; k++) chk(tbl[k].name, 32'(get_slot(tbl[k].slot)), 32'(tbl[k].exp));
        drain("t1");

        // 2: same load with valid toggling every other cycle
        pulse_start();
        chk("t2_pv_cleared", 32'(params_valid), 0);
        chk("t2_count_cleared", 32'(word_count), 0);
        stream(TOTAL, TOTAL-1, 1'b1, 0);
        chk("t2_ready_cycles", 32'(ready_cnt), 107);
        chk("t2_pv", 32'(params_valid), 1);
        drain("t2");
        check_bank("t2_bank");

        // 3: early s_last on beat 20 (data 26); slot 20 keeps its old value
        pulse_start();
        stream(TOTAL, 20, 1'b0, 6);
        chk("t3_err", 32'(err), 1);
        chk("t3_pv", 32'(params_valid), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_ready", 32'(s_ready), 0);
        chk("t3_slot20", 32'(get_slot(20)), 20);
        drain("t3");
        check_bank("t3_bank");
        pulse_start();
        chk("t3_err_cleared", 32'(err), 0);
        stream(TOTAL, TOTAL-1, 1'b0, 200);
        chk("t3_reload_pv", 32'(params_valid), 1);
        drain("t3_reload");

        // 4: h write-back in DONE
        @(negedge clk);
        h_wr = 1'b1;
        h_in = {17'd88, 17'd65};
        @(negedge clk);
        h_wr = 1'b0;
        mdl[4] = 17'd65;
        mdl[5] = 17'd88;
        chk("t4_h0", 32'(h_flat[0 +: W]), 65);
        chk("t4_h1", 32'(h_flat[W +: W]), 88);
        chk("t4_pv", 32'(params_valid), 1);
        check_bank("t4_bank");
        $display("h write-back checked");

        // 5: asynchronous reset during beat 30
        pulse_start();
        stream(30, -1, 1'b0, 300);
        chk("t5_count_mid", 32'(word_count), 30);
        s_valid = 1'b1;
        s_data  = 17'd330;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(s_ready), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_pv", 32'(params_valid), 0);
        chk("t5_count", 32'(word_count), 0);
        chk("t5_buses_zero", 32'((x_flat == '0) && (h_flat == '0) && (w_i_flat == '0)
                                 && (w_h_flat == '0) && (b_flat == '0)), 1);
        s_valid = 1'b0;
        sb_q.delete();
        for (int s = 0; s < TOTAL; s++) mdl[s] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle_ready", 32'(s_ready), 0);
        chk("t5_idle_busy", 32'(busy), 0);
        check_bank("t5_bank");
        $display("async reset checked");

        // 6: final beat without s_last
        pulse_start();
        stream(TOTAL, -1, 1'b0, 400);
        chk("t6_err", 32'(err), 1);
        chk("t6_pv", 32'(params_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        drain("t6");
        check_bank("t6_bank");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
